// File: rtl/module_barrido_teclado.sv
// 4x4 matrix keypad scanner: rotates an active-low row strobe, samples the
// columns once per row and debounces whole scans into single key events.
module module_barrido_teclado #(
    parameter int SCAN_DIV       = 27000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] column,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    // Scan classification: 0 = none, 1 = single key, 2 = multiple keys
    localparam logic [1:0] HIT_NONE   = 2'd0;
    localparam logic [1:0] HIT_SINGLE = 2'd1;
    localparam logic [1:0] HIT_MULTI  = 2'd2;

    logic [3:0]    col_s1_q, col_s2_q;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    row_q;
    logic [1:0]    ridx_q;
    logic [1:0]    hit_q, hit_d;
    logic [3:0]    scode_q, scode_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic          tick;
    logic          scan_done;
    logic [3:0]    low;
    logic [2:0]    nlow;
    logic [1:0]    cidx;
    logic [1:0]    hit_prev;
    logic [CW-1:0] cnt_inc;

    function automatic logic [3:0] key_map(input logic [1:0] r,
                                           input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;
            4'h1: k = 4'h2;
            4'h2: k = 4'h3;
            4'h3: k = 4'hA;
            4'h4: k = 4'h4;
            4'h5: k = 4'h5;
            4'h6: k = 4'h6;
            4'h7: k = 4'hB;
            4'h8: k = 4'h7;
            4'h9: k = 4'h8;
            4'hA: k = 4'h9;
            4'hB: k = 4'hC;
            4'hC: k = 4'hE;
            4'hD: k = 4'h0;
            4'hE: k = 4'hF;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    assign tick      = (div_q == DIV_LAST);
    assign scan_done = tick && (ridx_q == 2'd3);
    assign div_d     = tick ? '0 : div_q + DW'(1);

    assign low  = ~col_s2_q;
    assign nlow = {2'b0, low[0]} + {2'b0, low[1]}
                + {2'b0, low[2]} + {2'b0, low[3]};

    always_comb begin
        cidx = 2'd0;
        case (low)
            4'b0010: cidx = 2'd1;
            4'b0100: cidx = 2'd2;
            4'b1000: cidx = 2'd3;
            default: cidx = 2'd0;
        endcase
    end

    // Row 0 starts a fresh scan, so earlier results are ignored there
    assign hit_prev = (ridx_q == 2'd0) ? HIT_NONE : hit_q;

    always_comb begin
        hit_d   = hit_prev;
        scode_d = scode_q;
        if (nlow >= 3'd2 || (nlow == 3'd1 && hit_prev != HIT_NONE)) begin
            hit_d = HIT_MULTI;
        end else if (nlow == 3'd1) begin
            hit_d   = HIT_SINGLE;
            scode_d = key_map(ridx_q, cidx);
        end
    end

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        if (scan_done) begin
            case (state_q)
                ST_IDLE: begin
                    if (hit_d == HIT_SINGLE) begin
                        cand_d = scode_d;
                        cnt_d  = CW'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d     = ST_PRESSED;
                            key_code_d  = scode_d;
                            key_valid_d = 1'b1;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (hit_d == HIT_SINGLE && scode_d == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_d     = ST_PRESSED;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (hit_d == HIT_NONE) begin
                        cnt_d   = CW'(1);
                        state_d = (DEBOUNCE_SCANS == 1) ? ST_IDLE : ST_RELEASE;
                    end
                end
                default: begin
                    if (hit_d == HIT_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
            endcase
        end
        key_held_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_s1_q    <= 4'hF;
            col_s2_q    <= 4'hF;
            div_q       <= '0;
            row_q       <= 4'b1110;
            ridx_q      <= 2'd0;
            hit_q       <= HIT_NONE;
            scode_q     <= 4'h0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'h0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            col_s1_q    <= column;
            col_s2_q    <= col_s1_q;
            div_q       <= div_d;
            if (tick) begin
                row_q   <= {row_q[2:0], row_q[3]};
                ridx_q  <= ridx_q + 2'd1;
                hit_q   <= hit_d;
                scode_q <= scode_d;
            end
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign row       = row_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_module_barrido_teclado.sv
// Directed bench for the keypad scanner; a keypad model shorts the
// driven row onto the columns of every pressed key.
module tb_module_barrido_teclado;

    logic        clk;
    logic        rst;
    logic [3:0]  column;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    module_barrido_teclado #(
        .SCAN_DIV(4),
        .DEBOUNCE_SCANS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .column(column),
        .row(row),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        column = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row[r]) column[c] = 1'b0;
    end

    always @(posedge clk) if (key_valid === 1'b1) pulses++;

    // Lands on the negedge just after the edge that ends a full scan
    task automatic sync_scan();
        logic [3:0] prev;
        bit found;
        found = 0;
        prev = row;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (prev == 4'b0111 && row == 4'b1110) found = 1;
            prev = row;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL sync_scan: row never wrapped, row=%b", row);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        keys = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (row !== 4'b1110) begin
            errors++; $display("FAIL reset_row: got %b want 1110", row);
        end
        checks++;
        if (key_code !== 4'h0) begin
            errors++; $display("FAIL reset_code: got %h want 0", key_code);
        end
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", key_valid);
        end
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL reset_held: got %b want 0", key_held);
        end
        rst = 1'b1;
    endtask

    task automatic test_rotation();
        logic [3:0] exp_row;
        int idx;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            idx = ((i + 1) / 4) % 4;
            exp_row = 4'b1111 ^ (4'b0001 << idx);
            checks++;
            if (row !== exp_row) begin
                errors++;
                $display("FAIL rotation_row[%0d]: got %b want %b", i, row, exp_row);
            end
            checks++;
            if (key_valid !== 1'b0) begin
                errors++;
                $display("FAIL rotation_valid[%0d]: got %b want 0", i, key_valid);
            end
        end
    endtask

    task automatic test_single_press();
        int p0;
        sync_scan();
        p0 = pulses;
        keys[0] = 1'b1;
        repeat (31) @(negedge clk);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL single_early: got %b want 0", key_valid);
        end
        @(negedge clk);
        checks++;
        if (key_valid !== 1'b1) begin
            errors++; $display("FAIL single_pulse: got %b want 1", key_valid);
        end
        checks++;
        if (key_code !== 4'h1) begin
            errors++; $display("FAIL single_code: got %h want 1", key_code);
        end
        @(negedge clk);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++; $display("FAIL single_width: got %b want 0", key_valid);
        end
        repeat (63) @(negedge clk);
        checks++;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL single_held: got %b want 1", key_held);
        end
        checks++;
        if (pulses !== p0 + 1) begin
            errors++; $display("FAIL single_count: got %0d want %0d", pulses - p0, 1);
        end
        keys = '0;
        repeat (31) @(negedge clk);
        checks++;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL single_release_hold: got %b want 1", key_held);
        end
        @(negedge clk);
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL single_release_drop: got %b want 0", key_held);
        end
    endtask

    task automatic test_bounce();
        int p0;
        sync_scan();
        p0 = pulses;
        keys[1] = 1'b1;
        repeat (16) @(negedge clk);
        keys = '0;
        repeat (64) @(negedge clk);
        checks++;
        if (pulses !== p0) begin
            errors++; $display("FAIL bounce_count: got %0d want 0", pulses - p0);
        end
        checks++;
        if (key_code !== 4'h1) begin
            errors++; $display("FAIL bounce_code: got %h want 1", key_code);
        end
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL bounce_held: got %b want 0", key_held);
        end
    endtask

    task automatic test_sequence();
        int p0;
        sync_scan();
        p0 = pulses;
        keys[3] = 1'b1;
        repeat (48) @(negedge clk);
        checks++;
        if (key_code !== 4'hA) begin
            errors++; $display("FAIL seq_code_a: got %h want a", key_code);
        end
        checks++;
        if (pulses !== p0 + 1) begin
            errors++; $display("FAIL seq_count_a: got %0d want 1", pulses - p0);
        end
        keys = '0;
        repeat (48) @(negedge clk);
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL seq_held_gap: got %b want 0", key_held);
        end
        keys[4] = 1'b1;
        repeat (48) @(negedge clk);
        checks++;
        if (key_code !== 4'h4) begin
            errors++; $display("FAIL seq_code_4: got %h want 4", key_code);
        end
        checks++;
        if (pulses !== p0 + 2) begin
            errors++; $display("FAIL seq_count_4: got %0d want 2", pulses - p0);
        end
        checks++;
        if (key_held !== 1'b1) begin
            errors++; $display("FAIL seq_held_4: got %b want 1", key_held);
        end
        keys = '0;
        repeat (48) @(negedge clk);
    endtask

    task automatic test_multi_key();
        int p0;
        sync_scan();
        p0 = pulses;
        keys[0] = 1'b1;
        keys[2] = 1'b1;
        repeat (48) @(negedge clk);
        checks++;
        if (pulses !== p0) begin
            errors++; $display("FAIL multi_count: got %0d want 0", pulses - p0);
        end
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL multi_held: got %b want 0", key_held);
        end
        keys[2] = 1'b0;
        repeat (32) @(negedge clk);
        checks++;
        if (key_valid !== 1'b1) begin
            errors++; $display("FAIL multi_drop_pulse: got %b want 1", key_valid);
        end
        checks++;
        if (key_code !== 4'h1) begin
            errors++; $display("FAIL multi_drop_code: got %h want 1", key_code);
        end
        keys = '0;
        repeat (48) @(negedge clk);
        checks++;
        if (pulses !== p0 + 1) begin
            errors++; $display("FAIL multi_total: got %0d want 1", pulses - p0);
        end
    endtask

    task automatic test_reset_mid_press();
        int p0;
        sync_scan();
        keys[14] = 1'b1;
        repeat (48) @(negedge clk);
        checks++;
        if (key_code !== 4'hF || key_held !== 1'b1) begin
            errors++;
            $display("FAIL rmp_pre: got code %h held %b want f 1", key_code, key_held);
        end
        p0 = pulses;
        rst = 1'b0;
        #1;
        checks++;
        if (row !== 4'b1110) begin
            errors++; $display("FAIL rmp_row: got %b want 1110", row);
        end
        checks++;
        if (key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL rmp_outputs: got %h/%b/%b want 0/0/0", key_code, key_valid, key_held);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (31) @(negedge clk);
        checks++;
        if (pulses !== p0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmp_early: got %0d pulses valid %b want 0 0", pulses - p0, key_valid);
        end
        @(negedge clk);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'hF) begin
            errors++;
            $display("FAIL rmp_reaccept: got valid %b code %h want 1 f", key_valid, key_code);
        end
        keys = '0;
        repeat (48) @(negedge clk);
        checks++;
        if (key_held !== 1'b0) begin
            errors++; $display("FAIL rmp_release: got %b want 0", key_held);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single_press();
        test_bounce();
        test_sequence();
        test_multi_key();
        test_reset_mid_press();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/module_barrido_teclado.md
MODULE_BARRIDO_TECLADO -- requirements
Module: module_barrido_teclado

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 27000: clk cycles each row is driven before sampling; legal range 2 or more.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4: consecutive identical full scans required to accept a press or a release; legal range 1 or more.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port column, input, 4 bits: keypad columns, active-low, externally pulled up, asynchronous to clk.
REQ-006 SHALL have port row, output, 4 bits: keypad row drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port key_code, output, 4 bits: code of the last accepted key.
REQ-008 SHALL have port key_valid, output, 1 bit: one-cycle pulse when a new key is accepted.
REQ-009 SHALL have port key_held, output, 1 bit: high while the accepted key is considered pressed.

Function
REQ-010 SHALL pass column through a 2-flop synchronizer before any use.
REQ-011 SHALL use a prescaler counting 0..SCAN_DIV-1; a tick occurs at count SCAN_DIV-1.
REQ-012 SHALL, on each tick, sample the synchronized column for the currently driven row, then rotate row 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-013 SHALL treat four consecutive ticks, starting at row 1110, as one full scan, and classify each scan as NONE, SINGLE(code), or MULTI (two or more low bits across the scan).
REQ-014 SHALL map keys by row index r (low bit of row) and column index c (low bit of column) as follows:
- r0: 1, 2, 3, A
- r1: 4, 5, 6, B
- r2: 7, 8, 9, C
- r3: *, 0, #, D
REQ-015 SHALL encode keys as: digits = their value; A=0xA, B=0xB, C=0xC, D=0xD, *=0xE, #=0xF.
REQ-016 SHALL implement states IDLE, DEBOUNCE, PRESSED and RELEASE; the scan counter cnt saturates at DEBOUNCE_SCANS.
REQ-017 In IDLE: SINGLE(k) -> DEBOUNCE with cand=k and cnt=1; NONE or MULTI -> stay in IDLE.
REQ-018 In DEBOUNCE: SINGLE(cand) -> cnt+1; SINGLE(other), NONE or MULTI -> IDLE.
REQ-019 In DEBOUNCE, when cnt reaches DEBOUNCE_SCANS: go to PRESSED, load key_code=cand, and pulse key_valid for exactly one cycle.
REQ-020 With DEBOUNCE_SCANS=1, the pulse SHALL occur at the end of the first SINGLE scan.
REQ-021 key_valid SHALL assert on the clk edge immediately after the tick that completes the qualifying scan.
REQ-022 In PRESSED: key_held=1; SINGLE or MULTI -> stay, with no auto-repeat and no further key_valid; NONE -> RELEASE with cnt=1.
REQ-023 In RELEASE: key_held=1; NONE -> cnt+1, and at DEBOUNCE_SCANS -> IDLE with key_held=0; SINGLE or MULTI -> PRESSED.
REQ-024 key_code SHALL hold its value until the next key_valid.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 While rst=0, SHALL force:
- row=1110
- key_code=0
- key_valid=0
- key_held=0
- state=IDLE
- prescaler, cnt and cand = 0
- synchronizer flops = 1111
REQ-027 After rst releases, scanning SHALL restart at row 1110 with a fresh full scan.
REQ-028 A key still held across reset SHALL be re-accepted after DEBOUNCE_SCANS full scans.
REQ-029 Reset mid-operation SHALL NOT produce a key_valid pulse.

Verification (bench uses SCAN_DIV=4, DEBOUNCE_SCANS=2; keypad model shorts row to column)
REQ-030 Rotation: no key -> row cycles 1110,1101,1011,0111 with a 4-cycle dwell each; key_valid stays 0.
REQ-031 Single press: hold r0/c0 for 6 scans -> exactly one key_valid pulse with key_code=0x1 after the 2nd full scan; key_held=1 until 2 NONE scans after release.
REQ-032 Bounce: r0/c1 present for 1 scan, then absent -> no key_valid; key_code unchanged.
REQ-033 Sequence: press A (r0/c3), release, press 4 (r1/c0), release -> two pulses, key_code 0xA then 0x4; key_held drops between them.
REQ-034 Multi-key: r0/c0 and r0/c2 held together from IDLE -> no key_valid; drop c2 -> key_code=0x1 accepted after 2 scans.
REQ-035 Reset mid-press: assert rst in PRESSED while holding r3/c2 ->
- outputs 0 and row=1110 immediately
- after release of rst: key_valid with key_code=0xF after 2 scans
